// File: rtl/led_chaser_if.sv
// led_chaser_if: control/status bundle between the NPC control logic (master)
// and the LED pattern sequencer (slave).
interface led_chaser_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32
);
  logic             en;
  logic [CNT_W-1:0] div;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_pattern;
  logic [WIDTH-1:0] led;
  logic             step;
  logic             dir;

  modport master (
    output en, div, mode, load, load_pattern,
    input  led, step, dir
  );

  modport slave (
    input  en, div, mode, load, load_pattern,
    output led, step, dir
  );
endinterface

// File: rtl/led_chaser.sv
// led_chaser: prescaled LED pattern sequencer (rotate-left/right, bounce, fill, run-time load).
// Bounce mode is built only when LED_CHASER_BOUNCE_EN is defined; otherwise mode 10 rotates left.
module led_chaser #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  led_chaser_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  mode_e            mode_in;
  mode_e            mode_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] div_eff;
  logic             tick;
  logic [WIDTH-1:0] led_q;
  logic [WIDTH-1:0] led_nxt;
  logic [WIDTH-1:0] led_rol;
  logic [WIDTH-1:0] led_ror;
  logic [WIDTH-1:0] led_fill;
  logic [WIDTH-1:0] load_val;
  logic             step_q;

  assign mode_in = mode_e'(bus.mode);
  assign div_eff = (bus.div == '0) ? CNT_W'(1) : bus.div;
  assign tick    = (count >= div_eff);

  assign led_rol  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
  assign led_ror  = {led_q[0], led_q[WIDTH-1:1]};
  assign led_fill = (&led_q) ? WIDTH'(1) : {led_q[WIDTH-2:0], 1'b1};
  assign load_val = (bus.load_pattern == '0) ? WIDTH'(1) : bus.load_pattern;

`ifdef LED_CHASER_BOUNCE_EN
  logic             dir_q;
  logic             dir_nxt;
  logic             edge_hit;
  logic [WIDTH-1:0] led_up;
  logic [WIDTH-1:0] led_down;

  // Hitting the edge in the travel direction reverses within the same tick.
  assign edge_hit = dir_q ? led_q[0] : led_q[WIDTH-1];
  assign dir_nxt  = dir_q ^ edge_hit;
  assign led_up   = {led_q[WIDTH-2:0], 1'b0};
  assign led_down = {1'b0, led_q[WIDTH-1:1]};
`endif

  always_comb begin
    led_nxt = led_q;
    unique case (mode_q)
      MODE_ROL:    led_nxt = led_rol;
      MODE_ROR:    led_nxt = led_ror;
`ifdef LED_CHASER_BOUNCE_EN
      MODE_BOUNCE: led_nxt = dir_nxt ? led_down : led_up;
`else
      MODE_BOUNCE: led_nxt = led_rol;
`endif
      MODE_FILL:   led_nxt = led_fill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= WIDTH'(1);
      count  <= '0;
      step_q <= 1'b0;
      mode_q <= MODE_ROL;
    end else begin
      mode_q <= mode_in;
      step_q <= 1'b0;
      if (bus.load) begin
        led_q <= load_val;
        count <= '0;
      end else if (tick) begin
        led_q  <= led_nxt;
        count  <= '0;
        step_q <= 1'b1;
      end else if (bus.en) begin
        count <= count + CNT_W'(1);
      end
    end
  end

`ifdef LED_CHASER_BOUNCE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else if (bus.load || (mode_in != mode_q)) begin
      dir_q <= 1'b0;
    end else if (tick && (mode_q == MODE_BOUNCE)) begin
      dir_q <= dir_nxt;
    end
  end

  assign bus.dir = dir_q;
`else
  assign bus.dir = 1'b0;
`endif

  assign bus.led  = led_q;
  assign bus.step = step_q;

endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: scoreboard bench for led_chaser, a 16-LED and a 4-LED instance.
// Expected patterns are queued as stimulus is set up and popped on each step pulse.
module tb_led_chaser;

  typedef struct {
    logic [15:0] led;
    logic        dir;
  } exp_t;

  logic clk;
  logic rst16_n;
  logic rst4_n;
  int   checks;
  int   failures;
  exp_t sbq[$];

  led_chaser_if #(.WIDTH(16), .CNT_W(32)) bus16 ();
  led_chaser_if #(.WIDTH(4),  .CNT_W(32)) bus4 ();

  led_chaser #(.WIDTH(16), .CNT_W(32)) u_dut16 (
    .clk   (clk),
    .rst_n (rst16_n),
    .bus   (bus16)
  );

  led_chaser #(.WIDTH(4), .CNT_W(32)) u_dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] led, input logic dir);
    exp_t e;
    e.led = led;
    e.dir = dir;
    sbq.push_back(e);
  endtask

  // Wait for the next step pulse, then compare it against the scoreboard head.
  task automatic expect_step(input string tag, input bit sel4, input int exp_cycles);
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      seen = sel4 ? bus4.step : bus16.step;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'(n), 32'(exp_cycles));
    end else if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(0), 32'(1));
    end else begin
      e = sbq.pop_front();
      check({tag, "_period"}, 32'(n), 32'(exp_cycles));
      if (sel4) begin
        check({tag, "_led"}, 32'(bus4.led), 32'(e.led));
        check({tag, "_dir"}, 32'(bus4.dir), 32'(e.dir));
      end else begin
        check({tag, "_led"}, 32'(bus16.led), 32'(e.led));
      end
    end
  endtask

  initial begin
    logic [15:0] pat;
    logic [3:0]  b_led [7];
    logic        b_dir [7];
    int          nsteps;
    int          stray;

    checks   = 0;
    failures = 0;
    rst16_n  = 1'b0;
    rst4_n   = 1'b0;
    bus16.en = 1'b1; bus16.div = 32'd5; bus16.mode = 2'b00;
    bus16.load = 1'b0; bus16.load_pattern = '0;
    bus4.en = 1'b0; bus4.div = '0; bus4.mode = 2'b00;
    bus4.load = 1'b0; bus4.load_pattern = '0;

    // 1: reset values, rotate-left with div=5
    repeat (3) @(negedge clk);
    check("rst16_led", 32'(bus16.led), 32'h0001);
    check("rst16_step", 32'(bus16.step), 32'h0);
    check("rst16_dir", 32'(bus16.dir), 32'h0);
    pat = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      pat = {pat[14:0], pat[15]};
      push(pat, 1'b0);
    end
    rst16_n = 1'b1;
    for (int i = 0; i < 16; i++) expect_step("rol", 1'b0, 6);

    // 2: rotate-right, div=0 behaves as div=1
    bus16.mode = 2'b01;
    bus16.div  = '0;
    push(16'h8000, 1'b0);
    push(16'h4000, 1'b0);
    expect_step("ror_a", 1'b0, 2);
    expect_step("ror_b", 1'b0, 2);

    // 3: en low freezes the prescaler at count 3
    bus16.div = 32'd5;
    repeat (3) @(negedge clk);
    bus16.en = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus16.step) stray++;
    end
    check("hold_steps", 32'(stray), 32'd0);
    check("hold_led", 32'(bus16.led), 32'h4000);
    bus16.div = 32'd2;
    push(16'h2000, 1'b0);
    expect_step("div_drop", 1'b0, 1);

    // 4: load wins over a coincident tick, and a zero pattern lights bit 0
    bus16.en = 1'b1;
    repeat (2) @(negedge clk);
    bus16.load = 1'b1;
    bus16.load_pattern = 16'h00F0;
    @(negedge clk);
    bus16.load = 1'b0;
    check("load_led", 32'(bus16.led), 32'h00F0);
    check("load_step", 32'(bus16.step), 32'h0);
    push(16'h0078, 1'b0);
    expect_step("after_load", 1'b0, 3);
    bus16.load = 1'b1;
    bus16.load_pattern = '0;
    @(negedge clk);
    bus16.load = 1'b0;
    check("load_zero_led", 32'(bus16.led), 32'h0001);
    check("load_zero_step", 32'(bus16.step), 32'h0);

    // 5: mode 10 on the 4-LED instance
`ifdef LED_CHASER_BOUNCE_EN
    b_led = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    b_dir = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    nsteps = 7;
`else
    b_led = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    b_dir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    nsteps = 4;
`endif
    bus4.en = 1'b1;
    bus4.div = 32'd1;
    bus4.mode = 2'b10;
    @(negedge clk);
    check("rst4_led", 32'(bus4.led), 32'h1);
    check("rst4_dir", 32'(bus4.dir), 32'h0);
    for (int i = 0; i < nsteps; i++) push(16'(b_led[i]), b_dir[i]);
    rst4_n = 1'b1;
    for (int i = 0; i < nsteps; i++) expect_step("mode10", 1'b1, 2);

    // 6: fill, then asynchronous reset in the middle of the sequence
    bus4.load = 1'b1;
    bus4.load_pattern = 4'h1;
    bus4.mode = 2'b11;
    @(negedge clk);
    bus4.load = 1'b0;
    check("fill_load_led", 32'(bus4.led), 32'h1);
    push(16'h3, 1'b0);
    push(16'h7, 1'b0);
    push(16'hF, 1'b0);
    push(16'h1, 1'b0);
    push(16'h3, 1'b0);
    push(16'h7, 1'b0);
    for (int i = 0; i < 6; i++) expect_step("fill", 1'b1, 2);
    #2;
    rst4_n = 1'b0;
    #1;
    check("async_rst_led", 32'(bus4.led), 32'h1);
    check("async_rst_step", 32'(bus4.step), 32'h0);
    check("async_rst_dir", 32'(bus4.dir), 32'h0);
    @(negedge clk);
    rst4_n = 1'b1;
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
